c499_ecc_key_sequencer: RTL

- Sequential wrapper around the key-locked c499 single-error-correcting core (32 data bits, 8 check bits, 4 MUX key bits p1..p4, 6 XOR key bits X_1..X_6).
- Serially loads and holds the 10-bit unlock key.
- Streams data/check words into the combinational core through a valid/ready handshake.
- Waits a fixed settle time, then captures the corrected 32-bit word and presents it downstream under a second valid/ready handshake. Keeps a count of completed words.

---
 rtl/c499_ecc_key_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/c499_ecc_key_sequencer.sv
// Sequencer wrapped around the key-locked c499 SEC core: it loads the unlock key serially,
// drives one data/check word into the core, waits for the core to settle, and returns the corrected word.
module c499_ecc_key_sequencer #(
  parameter int KEY_W  = 10,
  parameter int DATA_W = 32,
  parameter int CHK_W  = 8,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_sen,
  input  logic              key_sin,
  output logic              key_done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W-1:0]  in_chk,
  output logic [DATA_W-1:0] core_data,
  output logic [CHK_W-1:0]  core_chk,
  output logic              core_en,
  output logic [KEY_W-1:0]  core_key,
  input  logic [DATA_W-1:0] core_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              busy
);

  localparam int BC_W = $clog2(KEY_W + 1);
  localparam int SW   = 4;
  localparam logic [BC_W-1:0]  KEY_FULL    = BC_W'(KEY_W);
  localparam logic [BC_W-1:0]  BC_ONE      = BC_W'(1);
  localparam logic [SW-1:0]    SETTLE_INIT = SW'(SETTLE);
  localparam logic [SW-1:0]    ST_ONE      = SW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_LOCKED = 3'd0,
    ST_LOAD   = 3'd1,
    ST_READY  = 3'd2,
    ST_DRIVE  = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  state_t              state_r, state_s;
  logic [KEY_W-1:0]    key_r, key_s, key_shift_s;
  logic [BC_W-1:0]     bit_cnt_r, bit_cnt_s;
  logic [SW-1:0]       settle_r, settle_s;
  logic                key_done_r, key_done_s;
  logic                in_ready_r, in_ready_s;
  logic [DATA_W-1:0]   core_data_r, core_data_s;
  logic [CHK_W-1:0]    core_chk_r, core_chk_s;
  logic                core_en_r, core_en_s;
  logic [KEY_W-1:0]    core_key_r, core_key_s;
  logic                out_valid_r, out_valid_s;
  logic [DATA_W-1:0]   out_data_r, out_data_s;
  logic [CNT_W-1:0]    word_cnt_r, word_cnt_s;
  logic                busy_r, busy_s;

  // Next-state and next-output decode for the sequencer.
  always_comb begin
    state_s     = state_r;
    key_s       = key_r;
    key_shift_s = {key_r[KEY_W-2:0], key_sin};
    bit_cnt_s   = bit_cnt_r;
    settle_s    = settle_r;
    key_done_s  = key_done_r;
    core_data_s = core_data_r;
    core_chk_s  = core_chk_r;
    core_en_s   = core_en_r;
    out_valid_s = out_valid_r;
    out_data_s  = out_data_r;
    word_cnt_s  = word_cnt_r;
    case (state_r)
      ST_LOCKED: begin
        if (key_sen) begin
          key_s     = key_shift_s;
          bit_cnt_s = BC_ONE;
          state_s   = ST_LOAD;
        end else begin
          state_s = ST_LOCKED;
        end
      end
      ST_LOAD: begin
        if (key_sen) begin
          key_s = key_shift_s;
          if (bit_cnt_r != KEY_FULL) begin
            bit_cnt_s = bit_cnt_r + BC_ONE;
          end else begin
            bit_cnt_s = bit_cnt_r;
          end
        end else if (bit_cnt_r == KEY_FULL) begin
          key_done_s = 1'b1;
          state_s    = ST_READY;
        end else begin
          bit_cnt_s = '0;
          state_s   = ST_LOCKED;
        end
      end
      ST_READY: begin
        // A key reload wins over a word offered on the same edge.
        if (key_sen) begin
          key_done_s = 1'b0;
          key_s      = key_shift_s;
          bit_cnt_s  = BC_ONE;
          state_s    = ST_LOAD;
        end else if (in_valid) begin
          core_data_s = in_data;
          core_chk_s  = in_chk;
          core_en_s   = 1'b1;
          settle_s    = SETTLE_INIT;
          state_s     = ST_DRIVE;
        end else begin
          state_s = ST_READY;
        end
      end
      ST_DRIVE: begin
        if (settle_r <= ST_ONE) begin
          out_data_s  = core_out;
          out_valid_s = 1'b1;
          state_s     = ST_HOLD;
        end else begin
          settle_s = settle_r - ST_ONE;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_s = 1'b0;
          core_en_s   = 1'b0;
          word_cnt_s  = word_cnt_r + CNT_ONE;
          state_s     = ST_READY;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s     = ST_LOCKED;
        key_done_s  = 1'b0;
        bit_cnt_s   = '0;
        core_en_s   = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
    in_ready_s = (state_s == ST_READY);
    busy_s     = (state_s == ST_LOAD) || (state_s == ST_DRIVE) || (state_s == ST_HOLD);
    // The core never sees a partially shifted key.
    core_key_s = key_done_s ? key_s : {KEY_W{1'b0}};
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_LOCKED;
      key_r       <= '0;
      bit_cnt_r   <= '0;
      settle_r    <= '0;
      key_done_r  <= 1'b0;
      in_ready_r  <= 1'b0;
      core_data_r <= '0;
      core_chk_r  <= '0;
      core_en_r   <= 1'b0;
      core_key_r  <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      word_cnt_r  <= '0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      key_r       <= key_s;
      bit_cnt_r   <= bit_cnt_s;
      settle_r    <= settle_s;
      key_done_r  <= key_done_s;
      in_ready_r  <= in_ready_s;
      core_data_r <= core_data_s;
      core_chk_r  <= core_chk_s;
      core_en_r   <= core_en_s;
      core_key_r  <= core_key_s;
      out_valid_r <= out_valid_s;
      out_data_r  <= out_data_s;
      word_cnt_r  <= word_cnt_s;
      busy_r      <= busy_s;
    end
  end

  assign key_done  = key_done_r;
  assign in_ready  = in_ready_r;
  assign core_data = core_data_r;
  assign core_chk  = core_chk_r;
  assign core_en   = core_en_r;
  assign core_key  = core_key_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign word_cnt  = word_cnt_r;
  assign busy      = busy_r;

endmodule
